// File: rtl/uart_rx_monitor_if.sv
// rtl/uart_rx_monitor_if.sv - receive FIFO handshake and status bundle for uart_rx_monitor
interface uart_rx_monitor_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]    io_data;
  logic          io_valid;
  logic          io_ready;
  logic          io_frameError;
  logic          io_break;
  logic          io_overrun;
  logic [CW-1:0] io_fifoCount;

  modport master (
    output io_data, io_valid, io_frameError, io_break, io_overrun, io_fifoCount,
    input  io_ready
  );

  modport slave (
    input  io_data, io_valid, io_frameError, io_break, io_overrun, io_fifoCount,
    output io_ready
  );
endinterface

// File: rtl/uart_rx_monitor.sv
// rtl/uart_rx_monitor.sv - 8N1 UART receiver, 16x oversampled with majority vote, into a small FIFO
module uart_rx_monitor #(
  parameter int SAMPLE_DIV = 27,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             io_axiClk,
  input  logic             io_asyncReset,
  input  logic             io_rxd,
  uart_rx_monitor_if.master bus
);
  localparam int TW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_STOP      = 3'd3;
  localparam logic [2:0] S_WAIT_HIGH = 3'd4;

  logic          rx_meta;
  logic          rxs;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [3:0]    sc;
  logic [2:0]    bit_cnt;
  logic [2:0]    state;
  logic          s7;
  logic          s8;
  logic          maj;
  logic [7:0]    shift;
  logic          push_req;
  logic          frame_error;
  logic          brk;
  logic          overrun;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          pop;
  logic          do_push;

  always_ff @(posedge io_axiClk or posedge io_asyncReset) begin
    if (io_asyncReset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= io_rxd;
      rxs     <= rx_meta;
    end
  end

  assign tick = (tick_cnt == TW'(SAMPLE_DIV - 1));

  always_ff @(posedge io_axiClk or posedge io_asyncReset) begin
    if (io_asyncReset) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // Bit value is the vote of samples at sc=7,8 and the live sample at sc=9.
  assign maj      = (s7 & s8) | (s7 & rxs) | (s8 & rxs);
  assign push_req = (state == S_STOP) && tick && (sc == 4'd9) && maj;

  always_ff @(posedge io_axiClk or posedge io_asyncReset) begin
    if (io_asyncReset) begin
      state       <= S_IDLE;
      sc          <= '0;
      bit_cnt     <= '0;
      s7          <= 1'b1;
      s8          <= 1'b1;
      shift       <= '0;
      frame_error <= 1'b0;
      brk         <= 1'b0;
    end else begin
      frame_error <= 1'b0;
      brk         <= 1'b0;
      if (tick) begin
        sc <= sc + 1'b1;
        if (sc == 4'd7) s7 <= rxs;
        if (sc == 4'd8) s8 <= rxs;
        case (state)
          S_IDLE: begin
            sc <= '0;
            if (!rxs) state <= S_START;
          end
          S_START: begin
            if (sc == 4'd9 && maj) begin
              state <= S_IDLE;
              sc    <= '0;
            end else if (sc == 4'd15) begin
              state   <= S_DATA;
              bit_cnt <= '0;
            end
          end
          S_DATA: begin
            if (sc == 4'd9) shift <= {maj, shift[7:1]};
            if (sc == 4'd15) begin
              if (bit_cnt == 3'd7) state <= S_STOP;
              else bit_cnt <= bit_cnt + 1'b1;
            end
          end
          S_STOP: begin
            if (sc == 4'd9) begin
              sc <= '0;
              if (maj) begin
                state <= S_IDLE;
              end else begin
                state       <= S_WAIT_HIGH;
                frame_error <= 1'b1;
                brk         <= (shift == 8'h00);
              end
            end
          end
          S_WAIT_HIGH: begin
            sc <= '0;
            if (rxs) state <= S_IDLE;
          end
          default: begin
            state <= S_IDLE;
            sc    <= '0;
          end
        endcase
      end
    end
  end

  assign full    = (count == CW'(FIFO_DEPTH));
  assign pop     = (count != '0) && bus.io_ready;
  // A full FIFO still takes a byte when the head leaves in the same cycle.
  assign do_push = push_req && (!full || pop);

  always_ff @(posedge io_axiClk or posedge io_asyncReset) begin
    if (io_asyncReset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      overrun <= push_req && full && !pop;
      if (do_push) begin
        mem[wr_ptr] <= shift;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !pop) count <= count + 1'b1;
      else if (pop && !do_push) count <= count - 1'b1;
    end
  end

  assign bus.io_data       = mem[rd_ptr];
  assign bus.io_valid      = (count != '0);
  assign bus.io_fifoCount  = count;
  assign bus.io_frameError = frame_error;
  assign bus.io_break      = brk;
  assign bus.io_overrun    = overrun;
endmodule
